// File: rtl/router_port_drain_if.sv
// Router-port read handshake plus the framed byte stream leaving one drain stage.
interface router_port_drain_if;
   logic       vld_out;
   logic [7:0] data_out;
   logic       read_enb;
   logic       m_valid;
   logic [7:0] m_data;
   logic       m_first;
   logic       m_last;
   logic       m_ready;
   logic       pkt_err;
   logic [5:0] pkt_len;
   logic       stall_timeout;

   modport master (
      input  vld_out, data_out, m_ready,
      output read_enb, m_valid, m_data, m_first, m_last, pkt_err, pkt_len, stall_timeout
   );

   modport slave (
      output vld_out, data_out, m_ready,
      input  read_enb, m_valid, m_data, m_first, m_last, pkt_err, pkt_len, stall_timeout
   );
endinterface

// File: rtl/router_port_drain.sv
// Drains one router output port into a skid FIFO, frames packets (header/payload/parity),
// checks parity and flushes itself when the router is about to soft-reset the port.
module router_port_drain #(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 30
) (
   input  logic                 clk,
   input  logic                 resetn,
   router_port_drain_if.master  port
);
   localparam int AW = $clog2(DEPTH);
   localparam int OW = AW + 1;
   localparam int SW = $clog2(TIMEOUT);

   typedef enum logic [1:0] {S_HDR, S_PAY, S_PAR} state_t;

   logic [7:0]    mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [OW-1:0] occ_q, occ_d;
   logic          inflight_q, inflight_d;
   state_t        state_q, state_d;
   logic [5:0]    cnt_q, cnt_d;
   logic [7:0]    acc_q, acc_d;
   logic [5:0]    pkt_len_q, pkt_len_d;
   logic [SW-1:0] stall_q, stall_d;
   logic [1:0]    flush_q, flush_d;

   logic          flush, rd_en, wr_en, pop, m_valid;
   logic          stall_cond, stall_hit;
   logic [7:0]    head;
   logic [OW:0]   pending;

   always_comb begin
      flush      = (flush_q != 2'd0);
      head       = mem_q[rd_ptr_q];
      // Reads are only issued while the skid can absorb every outstanding byte.
      pending    = {1'b0, occ_q} + {{OW{1'b0}}, inflight_q};
      rd_en      = port.vld_out & (pending < (OW+1)'(DEPTH)) & ~flush & ~resetn;
      m_valid    = (occ_q != '0) & ~flush & ~resetn;
      pop        = m_valid & port.m_ready;
      wr_en      = inflight_q & ~flush;
      stall_cond = port.vld_out & ~rd_en & ~flush & ~resetn;
      stall_hit  = stall_cond & (stall_q == SW'(TIMEOUT - 2));
   end

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      inflight_d = rd_en;
      state_d    = state_q;
      cnt_d      = cnt_q;
      acc_d      = acc_q;
      pkt_len_d  = pkt_len_q;
      stall_d    = stall_cond ? stall_q + 1'b1 : '0;
      flush_d    = flush ? flush_q - 2'd1 : 2'd0;
      if (stall_hit) begin
         stall_d = '0;
         flush_d = 2'd2;
      end

      if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_d = rd_ptr_q + 1'b1;
      occ_d = occ_q + OW'(wr_en) - OW'(pop);

      if (pop) begin
         case (state_q)
            S_HDR: begin
               pkt_len_d = head[7:2];
               cnt_d     = head[7:2];
               acc_d     = head;
               state_d   = (head[7:2] != 6'd0) ? S_PAY : S_PAR;
            end
            S_PAY: begin
               acc_d = acc_q ^ head;
               cnt_d = cnt_q - 6'd1;
               if (cnt_q == 6'd1) state_d = S_PAR;
            end
            default: begin
               state_d = S_HDR;
            end
         endcase
      end

      // The router is wiping its FIFO: drop everything and restart framing.
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         occ_d    = '0;
         state_d  = S_HDR;
         cnt_d    = '0;
         acc_d    = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (resetn) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         occ_q      <= '0;
         inflight_q <= 1'b0;
         state_q    <= S_HDR;
         cnt_q      <= '0;
         acc_q      <= '0;
         pkt_len_q  <= '0;
         stall_q    <= '0;
         flush_q    <= 2'd0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         occ_q      <= occ_d;
         inflight_q <= inflight_d;
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         acc_q      <= acc_d;
         pkt_len_q  <= pkt_len_d;
         stall_q    <= stall_d;
         flush_q    <= flush_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_ptr_q] <= port.data_out;
   end

   assign port.read_enb      = rd_en;
   assign port.m_valid       = m_valid;
   assign port.m_data        = head;
   assign port.m_first       = m_valid & (state_q == S_HDR);
   assign port.m_last        = m_valid & (state_q == S_PAR);
   assign port.pkt_err       = pop & (state_q == S_PAR) & ((acc_q ^ head) != 8'd0);
   assign port.pkt_len       = pkt_len_q;
   assign port.stall_timeout = stall_hit;
endmodule

// File: tb/tb_router_port_drain.sv
// Directed bench for router_port_drain: a small router FIFO model feeds the port and
// accepted stream beats are collected and compared against hand-built packets.
module tb_router_port_drain;
   localparam int DEPTH   = 4;
   localparam int TIMEOUT = 30;

   logic clk = 1'b0;
   logic resetn;

   router_port_drain_if bus();

   router_port_drain #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
      .clk    (clk),
      .resetn (resetn),
      .port   (bus)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_pass = 0;

   logic [7:0] rq [$];
   logic [7:0] expq [$];
   logic [7:0] bq_d [$];
   bit         bq_f [$];
   bit         bq_l [$];
   bit         bq_e [$];

   int cyc = 0;
   int first_re = -1;
   int first_mv = -1;
   int stall_run = 0;
   int to_run = -1;
   int to_mv = 0;
   int n_to = 0;
   int outstanding = 0;
   int occ_viol = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      else n_pass++;
   endtask

   // One clock: sample outputs at the falling edge, then model the router after the rising edge.
   task automatic tick();
      logic re;
      logic acc;
      @(negedge clk);
      re  = bus.read_enb;
      acc = bus.m_valid & bus.m_ready;
      if (acc) begin
         bq_d.push_back(bus.m_data);
         bq_f.push_back(bus.m_first);
         bq_l.push_back(bus.m_last);
         bq_e.push_back(bus.pkt_err);
      end
      if (re && outstanding >= DEPTH) occ_viol++;
      if (re && first_re < 0) first_re = cyc;
      if (bus.m_valid && first_mv < 0) first_mv = cyc;
      if (bus.vld_out && !re) stall_run++;
      else stall_run = 0;
      if (bus.stall_timeout) begin
         n_to++;
         to_run = stall_run;
         to_mv  = int'(bus.m_valid);
      end
      outstanding = outstanding + int'(re) - int'(acc);
      if (resetn || bus.stall_timeout) outstanding = 0;
      @(posedge clk);
      #1;
      cyc++;
      if (re && rq.size() > 0) bus.data_out = rq.pop_front();
      bus.vld_out = (rq.size() != 0);
   endtask

   task automatic push(input logic [7:0] b);
      rq.push_back(b);
      expq.push_back(b);
      bus.vld_out = 1'b1;
   endtask

   task automatic clr();
      bq_d.delete(); bq_f.delete(); bq_l.delete(); bq_e.delete();
      expq.delete();
      first_re = -1;
      first_mv = -1;
   endtask

   task automatic wait_beats(input int n, input int budget, input string tag);
      int k = 0;
      while (bq_d.size() < n && k < budget) begin
         tick();
         k++;
      end
      check(tag, bq_d.size(), n);
   endtask

   // Compare the collected beats against expq: data, header flag, end flag, error flag.
   task automatic check_pkt(input string tag, input bit exp_err);
      int n = expq.size();
      int nmis = 0, nf = 0, nl = 0, ne = 0;
      for (int i = 0; i < bq_d.size(); i++) begin
         if (i >= n || bq_d[i] !== expq[i]) nmis++;
         if (bq_f[i] != (i == 0)) nf++;
         if (bq_l[i] != (i == n - 1)) nl++;
         if (bq_e[i] != (exp_err && i == n - 1)) ne++;
      end
      check({tag, "_data"}, nmis, 0);
      check({tag, "_first"}, nf, 0);
      check({tag, "_last"}, nl, 0);
      check({tag, "_err"}, ne, 0);
   endtask

   initial begin
      int k;
      logic [7:0] par;
      logic [7:0] b;

      resetn       = 1'b1;
      bus.vld_out  = 1'b0;
      bus.data_out = 8'h00;
      bus.m_ready  = 1'b0;
      repeat (3) tick();
      resetn = 1'b0;
      check("reset_outs", 32'({bus.read_enb, bus.m_valid, bus.m_first, bus.m_last,
                               bus.pkt_err, bus.stall_timeout, bus.pkt_len}), 32'd0);

      // Single packet, L=3, correct parity 0x0D^0x11^0x22^0x33 = 0x0D
      clr();
      bus.m_ready = 1'b1;
      push(8'h0D); push(8'h11); push(8'h22); push(8'h33); push(8'h0D);
      wait_beats(5, 40, "t1_beats");
      check_pkt("t1", 1'b0);
      check("t1_pkt_len", 32'(bus.pkt_len), 32'd3);
      check("t1_latency", first_mv - first_re, 2);

      // Zero-length packet
      clr();
      push(8'h00); push(8'h00);
      wait_beats(2, 40, "t2_beats");
      check_pkt("t2", 1'b0);
      check("t2_pkt_len", 32'(bus.pkt_len), 32'd0);

      // Parity error: 0x1E differs from 0x0D
      clr();
      push(8'h0D); push(8'h11); push(8'h22); push(8'h33); push(8'h1E);
      wait_beats(5, 40, "t3_beats");
      check_pkt("t3", 1'b1);
      check("t3_pkt_len", 32'(bus.pkt_len), 32'd3);

      // Back-pressure: L=20, addr 2, m_ready 1-0-0-1
      clr();
      occ_viol = 0;
      push(8'h52);
      par = 8'h52;
      for (int i = 0; i < 20; i++) begin
         b = 8'(i * 13 + 5);
         push(b);
         par = par ^ b;
      end
      push(par);
      k = 0;
      while (bq_d.size() < 22 && k < 300) begin
         bus.m_ready = ((k % 4) == 0) || ((k % 4) == 3);
         tick();
         k++;
      end
      check("bp_beats", bq_d.size(), 22);
      check_pkt("bp", 1'b0);
      check("bp_occ", occ_viol, 0);
      check("bp_pkt_len", 32'(bus.pkt_len), 32'd20);

      // Timeout: skid full, no downstream acceptance
      clr();
      bus.m_ready = 1'b0;
      n_to = 0;
      for (int i = 0; i < 8; i++) push(8'(8'h1C + i));
      k = 0;
      while (n_to == 0 && k < 80) begin
         tick();
         k++;
      end
      check("to_fired", n_to, 1);
      check("to_cycle", to_run, TIMEOUT - 1);
      check("to_skid_valid", to_mv, 1);
      rq.delete();
      bus.vld_out = 1'b0;
      check("flush1_mvalid", 32'(bus.m_valid), 32'd0);
      tick();
      check("flush2_mvalid", 32'(bus.m_valid), 32'd0);
      clr();
      bus.m_ready = 1'b1;
      push(8'h08); push(8'hAA); push(8'hBB); push(8'h19);
      wait_beats(4, 40, "pf_beats");
      check_pkt("pf", 1'b0);
      check("to_single_pulse", n_to, 1);

      // Reset after header + 2 payload bytes
      clr();
      push(8'h0D); push(8'h11); push(8'h22); push(8'h33); push(8'h0D);
      wait_beats(3, 40, "rm_pre_beats");
      resetn = 1'b1;
      rq.delete();
      bus.vld_out = 1'b0;
      tick();
      resetn = 1'b0;
      check("rm_outs", 32'({bus.read_enb, bus.m_valid, bus.m_first, bus.m_last,
                            bus.pkt_err, bus.stall_timeout, bus.pkt_len}), 32'd0);
      clr();
      push(8'h04); push(8'h5A); push(8'h5E);
      wait_beats(3, 40, "rm_post_beats");
      check_pkt("rm", 1'b0);
      check("rm_pkt_len", 32'(bus.pkt_len), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
